// File: rtl/sramlike_2x1_arbiter.sv
// Two-to-one sram-like arbiter: data-over-instruction priority, request lock while
// waiting for addr_ok, and an in-order ID FIFO that routes each data_ok to its requester.
module sramlike_2x1_arbiter #(
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic        busy,
    output logic        err
);

    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUT);

    logic               lock_v_r, lock_v_s;
    logic               lock_src_r, lock_src_s;
    logic [MAX_OUT-1:0] fifo_r;
    logic [PW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]      cnt_r;
    logic               err_r;

    logic sel_s, sel_req_s, full_s, accept_s, drop_s, pop_s, spurious_s, head_s;

    // lock state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_v_r   <= 1'b0;
            lock_src_r <= 1'b0;
        end else begin
            lock_v_r   <= lock_v_s;
            lock_src_r <= lock_src_s;
        end
    end

    // lock next state: hold a stalled request's source until accepted or abandoned
    always_comb begin
        lock_v_s   = lock_v_r;
        lock_src_s = lock_src_r;
        if (accept_s) begin
            lock_v_s = 1'b0;
        end else if (drop_s) begin
            lock_v_s = 1'b0;
        end else if (mem_req) begin
            lock_v_s   = 1'b1;
            lock_src_s = sel_s;
        end else begin
            lock_v_s = lock_v_r;
        end
    end

    // source select, request mux and response routing
    always_comb begin
        if (lock_v_r) begin
            sel_s = lock_src_r;
        end else begin
            sel_s = data_req;
        end
        full_s = (cnt_r == CNT_FULL);
        if (sel_s) begin
            sel_req_s = data_req;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            sel_req_s = inst_req;
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
        mem_req      = sel_req_s & ~full_s;
        accept_s     = mem_req & mem_addr_ok;
        inst_addr_ok = accept_s & ~sel_s;
        data_addr_ok = accept_s & sel_s;
        drop_s       = lock_v_r & ~sel_req_s;
        pop_s        = mem_data_ok & (cnt_r != {CW{1'b0}});
        spurious_s   = mem_data_ok & (cnt_r == {CW{1'b0}});
        head_s       = fifo_r[rd_ptr_r];
        inst_data_ok = pop_s & ~head_s;
        data_data_ok = pop_s & head_s;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        busy         = (cnt_r != {CW{1'b0}});
        err          = err_r;
    end

    // ID FIFO, occupancy counter and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_r   <= {MAX_OUT{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                fifo_r[wr_ptr_r] <= sel_s;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
            if (spurious_s || drop_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule
